// File: rtl/exc_seq_pkg.sv
// ---------------------------------------------------------------------------
// exc_seq_pkg
// Shared constants for the ARM7 exception entry sequencer:
//   - exception class indices into the 6-bit request/ack vectors
//   - 3-bit register-file bank modes and 5-bit CPSR mode encodings
//   - vector offsets and return-address (LR) offsets
//   - sequencer state encodings
//   - helpers mapping a one-hot class to its bank, CPSR mode, vector and
//     LR offset, plus the CPSR image written on entry
// ---------------------------------------------------------------------------
package exc_seq_pkg;

   // Exception class indices (bit positions in exc_req / exc_ack)
   localparam int EXC_UND  = 0;
   localparam int EXC_SWI  = 1;
   localparam int EXC_PABT = 2;
   localparam int EXC_DABT = 3;
   localparam int EXC_IRQ  = 4;
   localparam int EXC_FIQ  = 5;
   localparam int EXC_NUM  = 6;

   // Register-file bank modes
   localparam logic [2:0] BANK_USR = 3'b000;
   localparam logic [2:0] BANK_SYS = 3'b001;
   localparam logic [2:0] BANK_FIQ = 3'b010;
   localparam logic [2:0] BANK_IRQ = 3'b011;
   localparam logic [2:0] BANK_SVC = 3'b100;
   localparam logic [2:0] BANK_ABT = 3'b101;
   localparam logic [2:0] BANK_UND = 3'b110;

   // CPSR[4:0] mode encodings
   localparam logic [4:0] CPSR_MODE_FIQ = 5'b10001;
   localparam logic [4:0] CPSR_MODE_IRQ = 5'b10010;
   localparam logic [4:0] CPSR_MODE_SVC = 5'b10011;
   localparam logic [4:0] CPSR_MODE_ABT = 5'b10111;
   localparam logic [4:0] CPSR_MODE_UND = 5'b11011;

   // Vector offsets from the vector base
   localparam logic [31:0] VEC_UND  = 32'h0000_0004;
   localparam logic [31:0] VEC_SWI  = 32'h0000_0008;
   localparam logic [31:0] VEC_PABT = 32'h0000_000C;
   localparam logic [31:0] VEC_DABT = 32'h0000_0010;
   localparam logic [31:0] VEC_IRQ  = 32'h0000_0018;
   localparam logic [31:0] VEC_FIQ  = 32'h0000_001C;

   // Return-address offsets added to the faulting/interrupted PC
   localparam logic [31:0] LR_OFF_DABT = 32'd8;
   localparam logic [31:0] LR_OFF_STD  = 32'd4;

   // Sequencer states
   typedef logic [2:0] state_t;
   localparam state_t ST_IDLE = 3'd0;
   localparam state_t ST_MODE = 3'd1;
   localparam state_t ST_LR   = 3'd2;
   localparam state_t ST_SPSR = 3'd3;
   localparam state_t ST_PC   = 3'd4;
   localparam state_t ST_DONE = 3'd5;

   // Bank mode for a one-hot class
   function automatic logic [2:0] bank_mode_f(input logic [5:0] cls);
      logic [2:0] m;
      case (cls)
         6'b000001: m = BANK_UND;
         6'b000010: m = BANK_SVC;
         6'b000100: m = BANK_ABT;
         6'b001000: m = BANK_ABT;
         6'b010000: m = BANK_IRQ;
         6'b100000: m = BANK_FIQ;
         default:   m = BANK_USR;
      endcase
      return m;
   endfunction

   // CPSR[4:0] mode for a one-hot class
   function automatic logic [4:0] cpsr_mode_f(input logic [5:0] cls);
      logic [4:0] m;
      case (cls)
         6'b000001: m = CPSR_MODE_UND;
         6'b000010: m = CPSR_MODE_SVC;
         6'b000100: m = CPSR_MODE_ABT;
         6'b001000: m = CPSR_MODE_ABT;
         6'b010000: m = CPSR_MODE_IRQ;
         6'b100000: m = CPSR_MODE_FIQ;
         default:   m = 5'b00000;
      endcase
      return m;
   endfunction

   // Vector offset for a one-hot class
   function automatic logic [31:0] vec_off_f(input logic [5:0] cls);
      logic [31:0] v;
      case (cls)
         6'b000001: v = VEC_UND;
         6'b000010: v = VEC_SWI;
         6'b000100: v = VEC_PABT;
         6'b001000: v = VEC_DABT;
         6'b010000: v = VEC_IRQ;
         6'b100000: v = VEC_FIQ;
         default:   v = 32'h0000_0000;
      endcase
      return v;
   endfunction

   // LR offset: data aborts return past the aborted load/store plus one
   function automatic logic [31:0] lr_off_f(input logic [5:0] cls);
      logic [31:0] o;
      if (cls[EXC_DABT]) begin
         o = LR_OFF_DABT;
      end else begin
         o = LR_OFF_STD;
      end
      return o;
   endfunction

   // CPSR image on entry: new mode, IRQs masked, ARM state, FIQ masked only
   // when entering FIQ (other entries keep the saved F bit)
   function automatic logic [31:0] entry_cpsr_f(input logic [31:0] cpsr,
                                                input logic [5:0]  cls);
      logic [31:0] v;
      v      = cpsr;
      v[4:0] = cpsr_mode_f(cls);
      v[5]   = 1'b0;
      v[7]   = 1'b1;
      if (cls[EXC_FIQ]) begin
         v[6] = 1'b1;
      end else begin
         v[6] = cpsr[6];
      end
      return v;
   endfunction

endpackage

// File: rtl/exc_priority_encoder.sv
// ---------------------------------------------------------------------------
// exc_priority_encoder
// Masks IRQ/FIQ with the CPSR I/F bits and picks the highest-priority
// eligible request: DABT > FIQ > IRQ > PABT > UND > SWI.
// Ports:
//   exc_req   in  6  level requests (class indices from exc_seq_pkg)
//   irq_mask  in  1  CPSR I bit
//   fiq_mask  in  1  CPSR F bit
//   winner    out 6  one-hot winning class (0 when none eligible)
//   valid     out 1  at least one request eligible
// ---------------------------------------------------------------------------
module exc_priority_encoder
   import exc_seq_pkg::*;
(
   input  logic [5:0] exc_req,
   input  logic       irq_mask,
   input  logic       fiq_mask,
   output logic [5:0] winner,
   output logic       valid
);

   logic [5:0] eligible_s;

   // Mask interrupts and select the single highest-priority eligible class
   always_comb begin
      eligible_s           = exc_req;
      eligible_s[EXC_IRQ]  = exc_req[EXC_IRQ] & ~irq_mask;
      eligible_s[EXC_FIQ]  = exc_req[EXC_FIQ] & ~fiq_mask;
      winner               = 6'b000000;
      if (eligible_s[EXC_DABT]) begin
         winner[EXC_DABT] = 1'b1;
      end else if (eligible_s[EXC_FIQ]) begin
         winner[EXC_FIQ] = 1'b1;
      end else if (eligible_s[EXC_IRQ]) begin
         winner[EXC_IRQ] = 1'b1;
      end else if (eligible_s[EXC_PABT]) begin
         winner[EXC_PABT] = 1'b1;
      end else if (eligible_s[EXC_UND]) begin
         winner[EXC_UND] = 1'b1;
      end else if (eligible_s[EXC_SWI]) begin
         winner[EXC_SWI] = 1'b1;
      end else begin
         winner = 6'b000000;
      end
      valid = |eligible_s;
   end

endmodule

// File: rtl/exc_entry_sequencer.sv
// ---------------------------------------------------------------------------
// exc_entry_sequencer
// Takes the highest-priority eligible ARM7 exception and runs the fixed
// entry sequence on the banked register file:
//   MODE (bank mode + CPSR) -> LR -> SPSR -> PC + flush -> DONE (ack).
// All outputs are registered; strobes are single-cycle pulses.
// Optional macro EXC_SEQ_HIVECS_EN selects VEC_BASE_HI as vector base,
// otherwise VEC_BASE_LO is used.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   exc_req[5:0]        level requests (UND,SWI,PABT,DABT,IRQ,FIQ)
//   core_ready          pipeline drained, entry may start
//   pc_in, cpsr_in      PC of faulting instruction, current CPSR
//   rf_write_*          register-file write port (LR=14, PC=15)
//   mode_write_en/out   bank-mode update
//   cpsr_write_en/value CPSR update
//   spsr_write_en/value SPSR write into the new mode's bank
//   flush               pipeline flush pulse with the PC write
//   busy                high from MODE through PC
//   exc_ack[5:0]        one-hot acknowledge of the taken class
// ---------------------------------------------------------------------------
module exc_entry_sequencer
   import exc_seq_pkg::*;
#(
   parameter logic [31:0] VEC_BASE_LO = 32'h0000_0000,
   parameter logic [31:0] VEC_BASE_HI = 32'hFFFF_0000
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [5:0]  exc_req,
   input  logic        core_ready,
   input  logic [31:0] pc_in,
   input  logic [31:0] cpsr_in,
   output logic        rf_write_en,
   output logic [3:0]  rf_write_reg,
   output logic [31:0] rf_write_value,
   output logic        mode_write_en,
   output logic [2:0]  mode_out,
   output logic        cpsr_write_en,
   output logic [31:0] cpsr_value,
   output logic        spsr_write_en,
   output logic [31:0] spsr_value,
   output logic        flush,
   output logic        busy,
   output logic [5:0]  exc_ack
);

`ifdef EXC_SEQ_HIVECS_EN
   localparam logic HIVECS = 1'b1;
`else
   localparam logic HIVECS = 1'b0;
`endif
   localparam logic [31:0] VEC_BASE = HIVECS ? VEC_BASE_HI : VEC_BASE_LO;

   state_t      state_r, state_nxt_s;
   logic [5:0]  cls_r, cls_nxt_s;
   logic [31:0] pc_r, pc_nxt_s;
   logic [31:0] cpsr_r, cpsr_nxt_s;
   logic [5:0]  win_s;
   logic        win_valid_s;
   logic        accept_s;

   logic        rf_we_nxt_s, mode_we_nxt_s, cpsr_we_nxt_s, spsr_we_nxt_s;
   logic        flush_nxt_s, busy_nxt_s;
   logic [3:0]  rf_reg_nxt_s;
   logic [31:0] rf_val_nxt_s, cpsr_val_nxt_s, spsr_val_nxt_s;
   logic [2:0]  mode_nxt_s;
   logic [5:0]  ack_nxt_s;

   logic        rf_we_r, mode_we_r, cpsr_we_r, spsr_we_r, flush_r, busy_r;
   logic [3:0]  rf_reg_r;
   logic [31:0] rf_val_r, cpsr_val_r, spsr_val_r;
   logic [2:0]  mode_r;
   logic [5:0]  ack_r;

   exc_priority_encoder u_prio (
      .exc_req  (exc_req),
      .irq_mask (cpsr_in[7]),
      .fiq_mask (cpsr_in[6]),
      .winner   (win_s),
      .valid    (win_valid_s)
   );

   // Next-state logic; requests are only looked at in IDLE
   always_comb begin
      state_nxt_s = state_r;
      accept_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (core_ready && win_valid_s) begin
               state_nxt_s = ST_MODE;
               accept_s    = 1'b1;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_MODE: state_nxt_s = ST_LR;
         ST_LR:   state_nxt_s = ST_SPSR;
         ST_SPSR: state_nxt_s = ST_PC;
         ST_PC:   state_nxt_s = ST_DONE;
         ST_DONE: state_nxt_s = ST_IDLE;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Capture class/PC/CPSR on acceptance; hold them for the whole sequence
   always_comb begin
      if (accept_s) begin
         cls_nxt_s  = win_s;
         pc_nxt_s   = pc_in;
         cpsr_nxt_s = cpsr_in;
      end else begin
         cls_nxt_s  = cls_r;
         pc_nxt_s   = pc_r;
         cpsr_nxt_s = cpsr_r;
      end
   end

   // Output decode from the next state so every output is a flop
   always_comb begin
      rf_we_nxt_s    = 1'b0;
      rf_reg_nxt_s   = 4'd0;
      rf_val_nxt_s   = 32'h0000_0000;
      mode_we_nxt_s  = 1'b0;
      mode_nxt_s     = 3'b000;
      cpsr_we_nxt_s  = 1'b0;
      cpsr_val_nxt_s = 32'h0000_0000;
      spsr_we_nxt_s  = 1'b0;
      spsr_val_nxt_s = 32'h0000_0000;
      flush_nxt_s    = 1'b0;
      busy_nxt_s     = 1'b0;
      ack_nxt_s      = 6'b000000;
      case (state_nxt_s)
         ST_MODE: begin
            mode_we_nxt_s  = 1'b1;
            mode_nxt_s     = bank_mode_f(cls_nxt_s);
            cpsr_we_nxt_s  = 1'b1;
            cpsr_val_nxt_s = entry_cpsr_f(cpsr_nxt_s, cls_nxt_s);
            busy_nxt_s     = 1'b1;
         end
         ST_LR: begin
            rf_we_nxt_s  = 1'b1;
            rf_reg_nxt_s = 4'd14;
            rf_val_nxt_s = pc_nxt_s + lr_off_f(cls_nxt_s);
            busy_nxt_s   = 1'b1;
         end
         ST_SPSR: begin
            spsr_we_nxt_s  = 1'b1;
            spsr_val_nxt_s = cpsr_nxt_s;
            busy_nxt_s     = 1'b1;
         end
         ST_PC: begin
            rf_we_nxt_s  = 1'b1;
            rf_reg_nxt_s = 4'd15;
            rf_val_nxt_s = VEC_BASE + vec_off_f(cls_nxt_s);
            flush_nxt_s  = 1'b1;
            busy_nxt_s   = 1'b1;
         end
         ST_DONE: begin
            ack_nxt_s = cls_nxt_s;
         end
         default: begin
            busy_nxt_s = 1'b0;
         end
      endcase
   end

   // State, latched exception context and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_IDLE;
         cls_r      <= 6'b000000;
         pc_r       <= 32'h0000_0000;
         cpsr_r     <= 32'h0000_0000;
         rf_we_r    <= 1'b0;
         rf_reg_r   <= 4'd0;
         rf_val_r   <= 32'h0000_0000;
         mode_we_r  <= 1'b0;
         mode_r     <= 3'b000;
         cpsr_we_r  <= 1'b0;
         cpsr_val_r <= 32'h0000_0000;
         spsr_we_r  <= 1'b0;
         spsr_val_r <= 32'h0000_0000;
         flush_r    <= 1'b0;
         busy_r     <= 1'b0;
         ack_r      <= 6'b000000;
      end else begin
         state_r    <= state_nxt_s;
         cls_r      <= cls_nxt_s;
         pc_r       <= pc_nxt_s;
         cpsr_r     <= cpsr_nxt_s;
         rf_we_r    <= rf_we_nxt_s;
         rf_reg_r   <= rf_reg_nxt_s;
         rf_val_r   <= rf_val_nxt_s;
         mode_we_r  <= mode_we_nxt_s;
         mode_r     <= mode_nxt_s;
         cpsr_we_r  <= cpsr_we_nxt_s;
         cpsr_val_r <= cpsr_val_nxt_s;
         spsr_we_r  <= spsr_we_nxt_s;
         spsr_val_r <= spsr_val_nxt_s;
         flush_r    <= flush_nxt_s;
         busy_r     <= busy_nxt_s;
         ack_r      <= ack_nxt_s;
      end
   end

   assign rf_write_en    = rf_we_r;
   assign rf_write_reg   = rf_reg_r;
   assign rf_write_value = rf_val_r;
   assign mode_write_en  = mode_we_r;
   assign mode_out       = mode_r;
   assign cpsr_write_en  = cpsr_we_r;
   assign cpsr_value     = cpsr_val_r;
   assign spsr_write_en  = spsr_we_r;
   assign spsr_value     = spsr_val_r;
   assign flush          = flush_r;
   assign busy           = busy_r;
   assign exc_ack        = ack_r;

endmodule

// File: tb/tb_exc_entry_sequencer.sv
// ---------------------------------------------------------------------------
// tb_exc_entry_sequencer
// Scoreboard bench: the driver applies inputs each cycle and, from a
// behavioural model of the exception rules, pushes the expected output
// records (with the cycle they are due) into a queue; a separate monitor
// compares DUT outputs against the queue head, and checks quiet cycles.
// ---------------------------------------------------------------------------
module tb_exc_entry_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [5:0]  exc_req = 6'd0;
   logic        core_ready = 1'b0;
   logic [31:0] pc_in = 32'd0;
   logic [31:0] cpsr_in = 32'd0;
   logic        rf_write_en, mode_write_en, cpsr_write_en, spsr_write_en;
   logic        flush, busy;
   logic [3:0]  rf_write_reg;
   logic [31:0] rf_write_value, cpsr_value, spsr_value;
   logic [2:0]  mode_out;
   logic [5:0]  exc_ack;

   exc_entry_sequencer dut (
      .clk(clk), .rst_n(rst_n), .exc_req(exc_req), .core_ready(core_ready),
      .pc_in(pc_in), .cpsr_in(cpsr_in),
      .rf_write_en(rf_write_en), .rf_write_reg(rf_write_reg),
      .rf_write_value(rf_write_value), .mode_write_en(mode_write_en),
      .mode_out(mode_out), .cpsr_write_en(cpsr_write_en),
      .cpsr_value(cpsr_value), .spsr_write_en(spsr_write_en),
      .spsr_value(spsr_value), .flush(flush), .busy(busy), .exc_ack(exc_ack)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        rf_we;
      logic [3:0]  rf_reg;
      logic [31:0] rf_val;
      logic        mode_we;
      logic [2:0]  mode;
      logic        cpsr_we;
      logic [31:0] cpsr_val;
      logic        spsr_we;
      logic [31:0] spsr_val;
      logic        flush;
      logic        busy;
      logic [5:0]  ack;
   } rec_t;

   // Exception tables indexed UND,SWI,PABT,DABT,IRQ,FIQ
   localparam logic [2:0]  BANK_TAB  [6] = '{3'b110, 3'b100, 3'b101, 3'b101, 3'b011, 3'b010};
   localparam logic [4:0]  CMODE_TAB [6] = '{5'b11011, 5'b10011, 5'b10111, 5'b10111, 5'b10010, 5'b10001};
   localparam logic [31:0] VEC_TAB   [6] = '{32'h04, 32'h08, 32'h0C, 32'h10, 32'h18, 32'h1C};
   localparam int          PRIO      [6] = '{3, 5, 4, 2, 0, 1};
`ifdef EXC_SEQ_HIVECS_EN
   localparam logic [31:0] BASE = 32'hFFFF_0000;
`else
   localparam logic [31:0] BASE = 32'h0000_0000;
`endif

   rec_t exp_q[$];
   int   at_q[$];
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;

   // stimulus state and model state
   logic [5:0]  req_v  = 6'd0;
   logic [31:0] pc_v   = 32'd0;
   logic [31:0] cpsr_v = 32'd0;
   logic        rdy_v  = 1'b0;
   int          busy_left = 0;
   int          model_cls = 0;
   int          accepts = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic rec_t obs_f();
      rec_t r;
      r.rf_we = rf_write_en;    r.rf_reg = rf_write_reg; r.rf_val = rf_write_value;
      r.mode_we = mode_write_en; r.mode = mode_out;
      r.cpsr_we = cpsr_write_en; r.cpsr_val = cpsr_value;
      r.spsr_we = spsr_write_en; r.spsr_val = spsr_value;
      r.flush = flush; r.busy = busy; r.ack = exc_ack;
      return r;
   endfunction

   // Expected records for taking class k with saved pc/cpsr, accepted in cycle c
   task automatic push_entry(input int k, input logic [31:0] pc,
                             input logic [31:0] cpsr, input int c);
      rec_t r;
      logic [31:0] nc;
      nc = cpsr;
      nc[4:0] = CMODE_TAB[k];
      nc[7] = 1'b1;
      nc[5] = 1'b0;
      if (k == 5) nc[6] = 1'b1;
      r = '0; r.mode_we = 1'b1; r.mode = BANK_TAB[k]; r.cpsr_we = 1'b1;
      r.cpsr_val = nc; r.busy = 1'b1;
      exp_q.push_back(r); at_q.push_back(c + 1);
      r = '0; r.rf_we = 1'b1; r.rf_reg = 4'd14;
      r.rf_val = pc + ((k == 3) ? 32'd8 : 32'd4); r.busy = 1'b1;
      exp_q.push_back(r); at_q.push_back(c + 2);
      r = '0; r.spsr_we = 1'b1; r.spsr_val = cpsr; r.busy = 1'b1;
      exp_q.push_back(r); at_q.push_back(c + 3);
      r = '0; r.rf_we = 1'b1; r.rf_reg = 4'd15; r.rf_val = BASE + VEC_TAB[k];
      r.flush = 1'b1; r.busy = 1'b1;
      exp_q.push_back(r); at_q.push_back(c + 4);
      r = '0; r.ack = 6'd1 << k;
      exp_q.push_back(r); at_q.push_back(c + 5);
   endtask

   // One clock of stimulus: apply inputs mid-cycle, then let the model decide
   task automatic step();
      int k;
      @(negedge clk);
      if (busy_left > 0) busy_left--;
      if (busy_left == 1) req_v[model_cls] = 1'b0;   // source clears after ack
      exc_req = req_v; cpsr_in = cpsr_v; pc_in = pc_v; core_ready = rdy_v;
      k = -1;
      if (busy_left == 0 && rst_n && rdy_v) begin
         for (int i = 0; i < 6; i++) begin
            int c;
            c = PRIO[i];
            if (k < 0 && req_v[c] && !(c == 4 && cpsr_v[7]) && !(c == 5 && cpsr_v[6]))
               k = c;
         end
      end
      if (k >= 0) begin
         push_entry(k, pc_v, cpsr_v, cyc);
         busy_left = 6;
         model_cls = k;
         accepts++;
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Monitor: compare due records, flag unexpected activity, check quiet cycles
   always @(negedge clk) begin
      rec_t o, e;
      o = obs_f();
      if (exp_q.size() > 0 && at_q[0] <= cyc) begin
         e = exp_q.pop_front();
         void'(at_q.pop_front());
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL seq_record cyc=%0d got=%h exp=%h", cyc, o, e);
         end
      end else begin
         checks++;
         if (o !== '0) begin
            errors++;
            $display("FAIL quiet_cycle cyc=%0d got=%h exp=%h", cyc, o, rec_t'(0));
         end
      end
   end

   task automatic check_zero(input string name);
      rec_t o;
      o = obs_f();
      checks++;
      if (o !== '0) begin
         errors++;
         $display("FAIL %s got=%h exp=0", name, o);
      end
   endtask

   initial begin
      #1 check_zero("reset_outputs");
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;

      // SWI only
      req_v = 6'b000010; cpsr_v = 32'h10; pc_v = 32'h100; rdy_v = 1'b1;
      run(8);
      // IRQ masked, then unmasked
      req_v = 6'b010000; cpsr_v = 32'h90; pc_v = 32'h2000;
      run(5);
      cpsr_v = 32'h10;
      run(8);
      // DABT and FIQ together: DABT first, FIQ right after
      req_v = 6'b101000; cpsr_v = 32'h10; pc_v = 32'h200;
      run(14);
      // LR wrap on data abort
      req_v = 6'b001000; pc_v = 32'hFFFF_FFFC;
      run(8);
      // UND held while core not ready
      req_v = 6'b000001; rdy_v = 1'b0; pc_v = 32'h440;
      run(5);
      rdy_v = 1'b1;
      run(8);

      // Reset during the SPSR state
      req_v = 6'b000010; cpsr_v = 32'h10; pc_v = 32'h300;
      step();
      run(3);
      #2;
      rst_n = 1'b0;
      req_v = 6'd0; exc_req = 6'd0;
      exp_q.delete(); at_q.delete();
      busy_left = 0;
      #1 check_zero("async_reset_mid_seq");
      run(2);
      #1 rst_n = 1'b1;
      run(8);

      // Randomised traffic
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(3) == 0) req_v[$urandom_range(5)] = 1'b1;
         if ($urandom_range(15) == 0) req_v[$urandom_range(5)] = 1'b0;
         if ($urandom_range(3) == 0) cpsr_v = $urandom;
         pc_v  = $urandom;
         rdy_v = ($urandom_range(3) != 0);
         step();
      end

      // Drain
      req_v = 6'd0;
      run(10);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain_queue got=%0d pending exp=0", exp_q.size());
      end
      checks++;
      if (accepts < 10) begin
         errors++;
         $display("FAIL accept_count got=%0d exp>=10", accepts);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
